// File: rtl/cellrv32_cpu_cp_fpu32_i2f_pkg.sv
// Shared FPU co-processor definitions: exception flag indices and rounding modes.
package cellrv32_cpu_cp_fpu32_i2f_pkg;

    // Exception flag bit positions within the 5-bit fflags vector
    localparam int fp_exc_nv_c = 0; // invalid operation
    localparam int fp_exc_dz_c = 1; // divide by zero
    localparam int fp_exc_of_c = 2; // overflow
    localparam int fp_exc_uf_c = 3; // underflow
    localparam int fp_exc_nx_c = 4; // inexact

    // RISC-V rounding mode encodings (frm / instruction rm field)
    localparam logic [2:0] rm_rne_c = 3'b000; // round to nearest, ties to even
    localparam logic [2:0] rm_rtz_c = 3'b001; // round towards zero
    localparam logic [2:0] rm_rdn_c = 3'b010; // round down (towards -inf)
    localparam logic [2:0] rm_rup_c = 3'b011; // round up (towards +inf)
    localparam logic [2:0] rm_rmm_c = 3'b100; // round to nearest, ties to max magnitude

endpackage

// File: rtl/cellrv32_cpu_cp_fpu32_i2f.sv
// Iterative integer-to-single-precision converter (FCVT.S.W / FCVT.S.WU).
// Normalises the magnitude one bit per cycle, then rounds with a single adder.
module cellrv32_cpu_cp_fpu32_i2f
    import cellrv32_cpu_cp_fpu32_i2f_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [2:0]      rmode_i,
    input  logic            funct_i,
    input  logic [XLEN-1:0] int_i,
    output logic [31:0]     result_o,
    output logic [4:0]      flags_o,
    output logic            done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPARE,
        S_NORMALIZE,
        S_ROUND,
        S_FINALIZE
    } state_t;

    typedef struct packed {
        logic [31:0] opnd;    // latched integer operand
        logic        funct;   // 1 = unsigned source
        logic [2:0]  rm;      // latched rounding mode
        logic        sign;
        logic        zero;    // operand was integer zero
        logic [31:0] mag;     // magnitude, shifted left until bit 31 is set
        logic [7:0]  exp;     // biased exponent, tracks the normalisation shift
        logic        sticky;
        logic        inexact;
        logic [22:0] mant;    // rounded mantissa (hidden bit dropped)
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl;

    logic        rnd_guard, rnd_round, rnd_sticky, rnd_inexact, rnd_inc;
    logic [30:0] rnd_sum;

    // Rounding decision and {exp, mant} increment on the normalised magnitude
    always_comb begin
        rnd_guard   = ctrl.mag[7];
        rnd_round   = ctrl.mag[6];
        rnd_sticky  = |ctrl.mag[5:0];
        rnd_inexact = rnd_guard | rnd_round | rnd_sticky;
        rnd_inc     = 1'b0;
        unique case (ctrl.rm)
            rm_rne_c: rnd_inc = rnd_guard & (rnd_round | rnd_sticky | ctrl.mag[8]);
            rm_rdn_c: rnd_inc = ctrl.sign & rnd_inexact;
            rm_rup_c: rnd_inc = ~ctrl.sign & rnd_inexact;
            rm_rmm_c: rnd_inc = rnd_guard;
            default:  rnd_inc = 1'b0; // RTZ and reserved codes truncate
        endcase
        // A mantissa carry ripples into the exponent; max exp is 159 so no overflow
        rnd_sum = {ctrl.exp, ctrl.mag[30:8]} + {30'd0, rnd_inc};
    end

    // Conversion FSM with registered result, flags and done strobe
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_IDLE;
            ctrl     <= '0;
            result_o <= '0;
            flags_o  <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        ctrl.opnd  <= int_i[31:0];
                        ctrl.funct <= funct_i;
                        ctrl.rm    <= rmode_i;
                        state      <= S_PREPARE;
                    end
                end
                S_PREPARE: begin
                    ctrl.sign    <= ~ctrl.funct & ctrl.opnd[31];
                    // Two's complement of 0x80000000 is itself, which is the right magnitude
                    ctrl.mag     <= (~ctrl.funct & ctrl.opnd[31]) ? (32'd0 - ctrl.opnd)
                                                                  : ctrl.opnd;
                    ctrl.exp     <= 8'd158;
                    ctrl.sticky  <= 1'b0;
                    ctrl.inexact <= 1'b0;
                    ctrl.zero    <= (ctrl.opnd == 32'd0);
                    state        <= (ctrl.opnd == 32'd0) ? S_FINALIZE : S_NORMALIZE;
                end
                S_NORMALIZE: begin
                    if (ctrl.mag[31]) begin
                        state <= S_ROUND;
                    end else begin
                        ctrl.mag <= {ctrl.mag[30:0], 1'b0};
                        ctrl.exp <= ctrl.exp - 8'd1;
                    end
                end
                S_ROUND: begin
                    ctrl.sticky  <= rnd_sticky;
                    ctrl.inexact <= rnd_inexact;
                    ctrl.exp     <= rnd_sum[30:23];
                    ctrl.mant    <= rnd_sum[22:0];
                    state        <= S_FINALIZE;
                end
                S_FINALIZE: begin
                    // Integer zero always converts to +0 and is exact
                    result_o <= ctrl.zero ? 32'd0 : {ctrl.sign, ctrl.exp, ctrl.mant};
                    flags_o  <= '0;
                    flags_o[fp_exc_nx_c] <= ctrl.inexact & ~ctrl.zero;
                    done_o   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cellrv32_cpu_cp_fpu32_i2f.md
Name: cellrv32_cpu_cp_fpu32_i2f

Overview:
- Iterative integer-to-float converter for FCVT.S.W / FCVT.S.WU. Counterpart of the float-to-int stage inside the same FPU co-processor.
- Takes a 32-bit signed or unsigned integer on a start pulse and normalises it with a shift-left FSM.
- Rounds per the RISC-V rounding mode and delivers an IEEE-754 single-precision word, exception flags and a one-cycle done pulse to the FPU result mux.

Parameters:
- XLEN, 32, integer data path width; only 32 is supported.

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- start_i  in  1  trigger; sampled only in S_IDLE
- rmode_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; other codes behave as RTZ
- funct_i  in  1  0 = signed source, 1 = unsigned source
- int_i  in  32  integer operand
- result_o  out  32  float result
- flags_o  out  5  exception flags, indexed by the package fp_exc_*_c constants
- done_o  out  1  single-cycle completion strobe

Behaviour:
- Reset: state S_IDLE; result_o = 0, flags_o = 0, done_o = 0; all internal registers = 0. Reset mid-operation aborts silently: no done_o, state returns to S_IDLE.
- S_IDLE:
  - On start_i = 1, latch int_i, funct_i and rmode_i; go to S_PREPARE.
  - done_o defaults to 0 in every cycle.
- S_PREPARE:
  - sign = ~funct & int[31].
  - mag = sign ? (0 - int) : int, 32-bit. 0x80000000 signed gives mag 0x80000000.
  - exp register = 158 (127 + 31); clear the sticky bit.
  - If mag == 0, set zero flag and go to S_FINALIZE; otherwise go to S_NORMALIZE.
- S_NORMALIZE, one step per cycle:
  - If mag[31] == 1, go to S_ROUND.
  - Else mag <<= 1 and exp -= 1.
  - Takes s+1 cycles, where s is the leading-zero count of mag (0..31).
- S_ROUND:
  - mant = mag[30:8]; guard = mag[7]; round = mag[6]; sticky = |mag[5:0].
  - inexact = guard | round | sticky.
  - Increment enable by mode:
    - RNE: guard & (round | sticky | mant[0]).
    - RTZ: 0.
    - RDN: sign & inexact.
    - RUP: ~sign & inexact.
    - RMM: guard.
  - Form {exp, mant} as a 31-bit value and add the enable bit, so a carry out of the mantissa increments exp. Maximum exp is 159, so no float overflow is possible.
  - Latch the result; go to S_FINALIZE.
- S_FINALIZE:
  - result_o = zero ? 0x00000000 : {sign, exp[7:0], mant}. Integer zero always gives +0.
  - flags_o: NX = inexact (0 for zero); NV, DZ, OF, UF = 0.
  - done_o <= 1; go to S_IDLE.
- Latency, counted from the clock edge that samples start_i:
  - non-zero operand: done_o asserts after edge 4+s;
  - zero operand: done_o asserts after edge 2.
- start_i while busy is ignored; no queuing.
- result_o and flags_o hold their value until the next S_FINALIZE. The caller samples them when done_o = 1.
- Input ports are not referenced after S_IDLE, so they may change freely during an operation.

Decomposition:
- Package: reuse the existing fp_exc_nv/dz/of/uf/nx_c indices. Add a shared rounding-mode localparam set (rm_rne_c … rm_rmm_c) for reuse by every FPU stage.
- The FSM state enum and the internal control struct stay local to the module.
- No sub-module: the normaliser is iterative and the rounder is a single adder.

Test Plan:
- Signed 0x00000001, RNE -> result 0x3F800000, flags 0, done_o after 35 edges.
- Signed 0xFFFFFFFF -> 0xBF800000 flags 0. Signed 0x80000000 -> 0xCF000000, flags 0, done_o after 4 edges.
- Unsigned 0xFFFFFFFF:
  - RNE -> 0x4F800000, NX = 1 (mantissa carry bumps exp);
  - RTZ -> 0x4F7FFFFF, NX = 1.
- 0x01000001 (16777217):
  - RNE tie-to-even -> 0x4B800000, NX = 1;
  - RUP -> 0x4B800001.
- Signed -16777217:
  - RDN -> 0xCB800001;
  - RTZ -> 0xCB800000.
- Zero input, any mode -> 0x00000000, flags 0, done after 2 edges.
- start_i pulsed while busy -> ignored.
- rstn_i asserted in S_NORMALIZE -> no done_o, result_o = 0, and the next operation completes correctly.
